// File: rtl/sync_ram_pkg.sv
// Shared constants and the byte-lane merge used by sync_ram_dp_be.
package sync_ram_pkg;

  localparam int unsigned RDW_READ_FIRST  = 0;
  localparam int unsigned RDW_WRITE_FIRST = 1;

  // Widest word/lane count the merge helper supports; callers zero-extend into these.
  localparam int unsigned MaxDwidth = 1024;
  localparam int unsigned MaxLanes  = 128;

  function automatic logic [MaxDwidth-1:0] byte_merge(
    input logic [MaxDwidth-1:0] old_word,
    input logic [MaxDwidth-1:0] new_word,
    input logic [MaxLanes-1:0]  lane_en,
    input int unsigned          lane_w
  );
    logic [MaxDwidth-1:0] res;
    int unsigned          lane;
    res = old_word;
    for (int unsigned i = 0; i < MaxDwidth; i++) begin
      lane = i / lane_w;
      if (lane < MaxLanes && lane_en[lane[6:0]]) begin
        res[i[9:0]] = new_word[i[9:0]];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_ram_rd_pipe.sv
// Per-port read response path: read-data register, optional output register and valid strobe.
module sync_ram_rd_pipe
  import sync_ram_pkg::*;
#(
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned OUT_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [DWIDTH-1:0] rd_data,
  output logic [DWIDTH-1:0] q,
  output logic              q_valid
);

  logic [DWIDTH-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = rd_en;
    if (rd_en) begin
      data_d = rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DWIDTH-1:0] out_q, out_d;
    logic              out_valid_q, out_valid_d;

    // Only a completed read advances; reset drops anything still in flight.
    always_comb begin
      out_d       = out_q;
      out_valid_d = valid_q;
      if (valid_q) begin
        out_d = data_q;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        out_q       <= '0;
        out_valid_q <= 1'b0;
      end else begin
        out_q       <= out_d;
        out_valid_q <= out_valid_d;
      end
    end

    assign q       = out_q;
    assign q_valid = out_valid_q;
  end else begin : g_no_out_reg
    assign q       = data_q;
    assign q_valid = valid_q;
  end

endmodule

// File: rtl/sync_ram_dp_be.sv
// Dual-port byte-enable synchronous RAM; collision tracking is built only when
// SYNC_RAM_COLLISION_DETECT_EN is defined.
module sync_ram_dp_be
  import sync_ram_pkg::*;
#(
  parameter int unsigned DWIDTH   = 32,
  parameter int unsigned BYTE     = 8,
  parameter int unsigned AWIDTH   = 8,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned RDW_MODE = 0,
  parameter int unsigned OUT_REG  = 0,
  localparam int unsigned NB      = DWIDTH / BYTE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en0,
  input  logic [NB-1:0]     we0,
  input  logic [AWIDTH-1:0] addr0,
  input  logic [DWIDTH-1:0] d0,
  output logic [DWIDTH-1:0] q0,
  output logic              q0_valid,
  input  logic              en1,
  input  logic [NB-1:0]     we1,
  input  logic [AWIDTH-1:0] addr1,
  input  logic [DWIDTH-1:0] d1,
  output logic [DWIDTH-1:0] q1,
  output logic              q1_valid
`ifdef SYNC_RAM_COLLISION_DETECT_EN
  ,
  output logic              collision,
  output logic [AWIDTH-1:0] coll_addr
`endif
);

  localparam int unsigned AIdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  function automatic logic [DWIDTH-1:0] merge(
    input logic [DWIDTH-1:0] old_word,
    input logic [DWIDTH-1:0] new_word,
    input logic [NB-1:0]     lanes
  );
    return DWIDTH'(byte_merge(MaxDwidth'(old_word), MaxDwidth'(new_word),
                              MaxLanes'(lanes), BYTE));
  endfunction

  logic [DWIDTH-1:0] mem_q [DEPTH] = '{default: '0};

  logic              acc0, acc1, in0, in1;
  logic [AIdxW-1:0]  idx0, idx1;
  logic [DWIDTH-1:0] old0, old1, rd0, rd1;
  logic              wr0, wr1, wr1_eff, same_addr;
  logic [DWIDTH-1:0] wdata0, wdata1, base0;

  assign acc0      = en0 & ~rst;
  assign acc1      = en1 & ~rst;
  assign in0       = 32'(addr0) < DEPTH;
  assign in1       = 32'(addr1) < DEPTH;
  assign idx0      = addr0[AIdxW-1:0];
  assign idx1      = addr1[AIdxW-1:0];
  assign same_addr = addr0 == addr1;

  always_comb begin
    old0 = '0;
    old1 = '0;
    if (in0) old0 = mem_q[idx0];
    if (in1) old1 = mem_q[idx1];
  end

  // Write-first only merges this port's own lanes; the other port always sees the old word.
  always_comb begin
    rd0 = old0;
    rd1 = old1;
    if (RDW_MODE == RDW_WRITE_FIRST) begin
      if (in0) rd0 = merge(old0, d0, we0);
      if (in1) rd1 = merge(old1, d1, we1);
    end
  end

  // Same-address double write folds into one port-0 write with port 0 winning shared lanes.
  always_comb begin
    wr0     = acc0 & in0 & (|we0);
    wr1     = acc1 & in1 & (|we1);
    wr1_eff = wr1 & ~(wr0 & same_addr);
    base0   = (wr1 && same_addr) ? merge(old0, d1, we1) : old0;
    wdata0  = merge(base0, d0, we0);
    wdata1  = merge(old1, d1, we1);
  end

  always_ff @(posedge clk) begin
    if (wr1_eff) mem_q[idx1] <= wdata1;
    if (wr0)     mem_q[idx0] <= wdata0;
  end

  sync_ram_rd_pipe #(
    .DWIDTH  (DWIDTH),
    .OUT_REG (OUT_REG)
  ) u_rd_pipe0 (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (acc0),
    .rd_data (rd0),
    .q       (q0),
    .q_valid (q0_valid)
  );

  sync_ram_rd_pipe #(
    .DWIDTH  (DWIDTH),
    .OUT_REG (OUT_REG)
  ) u_rd_pipe1 (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (acc1),
    .rd_data (rd1),
    .q       (q1),
    .q_valid (q1_valid)
  );

`ifdef SYNC_RAM_COLLISION_DETECT_EN
  logic              collision_q, collision_d;
  logic [AWIDTH-1:0] coll_addr_q, coll_addr_d;

  always_comb begin
    collision_d = collision_q;
    coll_addr_d = coll_addr_q;
    if (!collision_q && acc0 && acc1 && same_addr && ((|we0) || (|we1))) begin
      collision_d = 1'b1;
      coll_addr_d = addr0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      collision_q <= 1'b0;
      coll_addr_q <= '0;
    end else begin
      collision_q <= collision_d;
      coll_addr_q <= coll_addr_d;
    end
  end

  assign collision = collision_q;
  assign coll_addr = coll_addr_q;
`endif

endmodule

// File: tb/tb_sync_ram_dp_be.sv
// Bench for sync_ram_dp_be: instance A (read-first, no output reg) and instance B
// (write-first, output reg) share stimulus and are checked against a word-array model.
module tb_sync_ram_dp_be;

  localparam int unsigned DW    = 32;
  localparam int unsigned NB    = 4;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 200;

  logic          clk = 1'b0;
  logic          rst;
  logic          en0, en1;
  logic [NB-1:0] we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] d0, d1;
  logic [DW-1:0] qa0, qa1, qb0, qb1;
  logic          va0, va1, vb0, vb1;
`ifdef SYNC_RAM_COLLISION_DETECT_EN
  logic          col_a, col_b;
  logic [AW-1:0] caddr_a, caddr_b;
`endif

  always #5 clk = ~clk;

  sync_ram_dp_be #(
    .DWIDTH(DW), .BYTE(8), .AWIDTH(AW), .DEPTH(DEPTH), .RDW_MODE(0), .OUT_REG(0)
  ) u_dut_a (
    .clk(clk), .rst(rst),
    .en0(en0), .we0(we0), .addr0(addr0), .d0(d0), .q0(qa0), .q0_valid(va0),
    .en1(en1), .we1(we1), .addr1(addr1), .d1(d1), .q1(qa1), .q1_valid(va1)
`ifdef SYNC_RAM_COLLISION_DETECT_EN
    , .collision(col_a), .coll_addr(caddr_a)
`endif
  );

  sync_ram_dp_be #(
    .DWIDTH(DW), .BYTE(8), .AWIDTH(AW), .DEPTH(DEPTH), .RDW_MODE(1), .OUT_REG(1)
  ) u_dut_b (
    .clk(clk), .rst(rst),
    .en0(en0), .we0(we0), .addr0(addr0), .d0(d0), .q0(qb0), .q0_valid(vb0),
    .en1(en1), .we1(we1), .addr1(addr1), .d1(d1), .q1(qb1), .q1_valid(vb1)
`ifdef SYNC_RAM_COLLISION_DETECT_EN
    , .collision(col_b), .coll_addr(caddr_b)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model: memory words plus the response each instance owes per port.
  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] exp_a_q [2];
  logic          exp_a_v [2];
  logic [DW-1:0] exp_b_q [2];
  logic          exp_b_v [2];
  logic          pend_v  [2];
  logic [DW-1:0] pend_d  [2];
  logic          exp_col;
  logic [AW-1:0] exp_caddr;

  task automatic step(input logic r,
                      input logic e0, input logic [NB-1:0] w0, input logic [AW-1:0] a0,
                      input logic [DW-1:0] x0,
                      input logic e1, input logic [NB-1:0] w1, input logic [AW-1:0] a1,
                      input logic [DW-1:0] x1);
    logic          acc [2];
    logic [NB-1:0] w   [2];
    logic [AW-1:0] a   [2];
    logic [DW-1:0] x   [2];
    logic [DW-1:0] old_w [2];
    logic [DW-1:0] wf  [2];
    @(negedge clk);
    rst = r;
    en0 = e0; we0 = w0; addr0 = a0; d0 = x0;
    en1 = e1; we1 = w1; addr1 = a1; d1 = x1;
    acc[0] = e0 && !r; w[0] = w0; a[0] = a0; x[0] = x0;
    acc[1] = e1 && !r; w[1] = w1; a[1] = a1; x[1] = x1;
    for (int p = 0; p < 2; p++) begin
      old_w[p] = '0;
      if (a[p] < DEPTH) old_w[p] = mem_m[a[p]];
      wf[p] = old_w[p];
      if (a[p] < DEPTH) begin
        for (int b = 0; b < NB; b++) if (w[p][b]) wf[p][8*b +: 8] = x[p][8*b +: 8];
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (r) begin
        exp_a_q[p] = '0; exp_a_v[p] = 1'b0;
        exp_b_q[p] = '0; exp_b_v[p] = 1'b0;
      end else begin
        exp_a_v[p] = acc[p];
        if (acc[p]) exp_a_q[p] = old_w[p];
        exp_b_v[p] = pend_v[p];
        if (pend_v[p]) exp_b_q[p] = pend_d[p];
      end
      pend_v[p] = acc[p];
      pend_d[p] = wf[p];
    end
    // Port 1 applied first so port 0 overrides lanes both ports write.
    for (int p = 1; p >= 0; p--) begin
      if (acc[p] && a[p] < DEPTH) begin
        for (int b = 0; b < NB; b++) if (w[p][b]) mem_m[a[p]][8*b +: 8] = x[p][8*b +: 8];
      end
    end
    if (r) begin
      exp_col = 1'b0; exp_caddr = '0;
    end else if (!exp_col && acc[0] && acc[1] && a0 == a1 && ((|w0) || (|w1))) begin
      exp_col = 1'b1; exp_caddr = a0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 4'hF, 8'd0, 32'hFFFF_FFFF, 1'b1, 4'hF, 8'd1, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, 4'hF, 8'd0, 32'hFFFF_FFFF, 1'b0, '0, '0, '0);
    checks++;
    if ({qa0, qa1, qb0, qb1} !== '0) begin
      errors++; $display("FAIL reset_q: got %h %h %h %h required 0", qa0, qa1, qb0, qb1);
    end
    checks++;
    if ({va0, va1, vb0, vb1} !== 4'b0) begin
      errors++; $display("FAIL reset_valid: got %b%b%b%b required 0000", va0, va1, vb0, vb1);
    end
`ifdef SYNC_RAM_COLLISION_DETECT_EN
    checks++;
    if (col_a !== 1'b0 || col_b !== 1'b0) begin
      errors++; $display("FAIL reset_collision: got %b %b required 0", col_a, col_b);
    end
`endif
    step(1'b0, 1'b1, 4'h0, 8'd0, '0, 1'b0, '0, '0, '0);
    checks++;
    if (qa0 !== 32'h0 || va0 !== 1'b1) begin
      errors++; $display("FAIL reset_nowrite: got %h v=%b required 0 v=1", qa0, va0);
    end
    idle();
  endtask

  task automatic test_write_readback();
    step(1'b0, 1'b1, 4'hF, 8'd5, 32'hDEAD_BEEF, 1'b0, '0, '0, '0);
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 4'h0, 8'd5, '0);
    checks++;
    if (qa1 !== 32'hDEAD_BEEF || va1 !== 1'b1) begin
      errors++; $display("FAIL wr_rd_a: got %h v=%b required deadbeef v=1", qa1, va1);
    end
    checks++;
    if (vb1 !== 1'b0) begin
      errors++; $display("FAIL wr_rd_b_early: got v=%b required v=0", vb1);
    end
    idle();
    checks++;
    if (qb1 !== 32'hDEAD_BEEF || vb1 !== 1'b1 || va1 !== 1'b0) begin
      errors++;
      $display("FAIL wr_rd_b: got %h vb=%b va=%b required deadbeef 1 0", qb1, vb1, va1);
    end
    idle();
    checks++;
    if (qa1 !== 32'hDEAD_BEEF || vb1 !== 1'b0) begin
      errors++; $display("FAIL wr_rd_hold: got %h vb=%b required deadbeef 0", qa1, vb1);
    end
  endtask

  task automatic test_byte_lanes();
    step(1'b0, 1'b1, 4'hF, 8'd3, 32'h1122_3344, 1'b0, '0, '0, '0);
    step(1'b0, 1'b1, 4'b0101, 8'd3, 32'hAABB_CCDD, 1'b0, '0, '0, '0);
    step(1'b0, 1'b1, 4'h0, 8'd3, '0, 1'b0, '0, '0, '0);
    checks++;
    if (qa0 !== 32'h11BB_33DD) begin
      errors++; $display("FAIL byte_lanes_a: got %h required 11bb33dd", qa0);
    end
    idle();
    checks++;
    if (qb0 !== 32'h11BB_33DD || vb0 !== 1'b1) begin
      errors++; $display("FAIL byte_lanes_b: got %h v=%b required 11bb33dd v=1", qb0, vb0);
    end
  endtask

  task automatic test_dual_write();
    step(1'b0, 1'b1, 4'b0001, 8'd9, 32'h0000_00AA, 1'b1, 4'b0011, 8'd9, 32'h0000_BBCC);
`ifdef SYNC_RAM_COLLISION_DETECT_EN
    checks++;
    if (col_a !== 1'b1 || caddr_a !== 8'd9 || col_b !== 1'b1 || caddr_b !== 8'd9) begin
      errors++;
      $display("FAIL collision_set: got %b/%0d %b/%0d required 1/9", col_a, caddr_a, col_b,
               caddr_b);
    end
`endif
    step(1'b0, 1'b1, 4'h0, 8'd9, '0, 1'b0, '0, '0, '0);
    checks++;
    if (qa0 !== 32'h0000_BBAA) begin
      errors++; $display("FAIL dual_write_a: got %h required 0000bbaa", qa0);
    end
    idle();
    checks++;
    if (qb0 !== 32'h0000_BBAA) begin
      errors++; $display("FAIL dual_write_b: got %h required 0000bbaa", qb0);
    end
  endtask

  task automatic test_rdw();
    step(1'b0, 1'b1, 4'hF, 8'd7, 32'h1, 1'b0, '0, '0, '0);
    step(1'b0, 1'b1, 4'hF, 8'd7, 32'h2, 1'b1, 4'h0, 8'd7, '0);
    checks++;
    if (qa0 !== 32'h1 || qa1 !== 32'h1) begin
      errors++; $display("FAIL rdw_read_first: got %h %h required 1 1", qa0, qa1);
    end
    idle();
    checks++;
    if (qb0 !== 32'h2) begin
      errors++; $display("FAIL rdw_write_first: got %h required 2", qb0);
    end
    checks++;
    if (qb1 !== 32'h1) begin
      errors++; $display("FAIL rdw_cross_port: got %h required 1", qb1);
    end
`ifdef SYNC_RAM_COLLISION_DETECT_EN
    checks++;
    if (col_a !== 1'b1 || caddr_a !== 8'd9 || col_b !== 1'b1 || caddr_b !== 8'd9) begin
      errors++; $display("FAIL collision_sticky: got %0d %0d required 9", caddr_a, caddr_b);
    end
`endif
  endtask

  task automatic test_rst_pipeline();
    step(1'b0, 1'b1, 4'hF, 8'd12, 32'hCAFE_F00D, 1'b0, '0, '0, '0);
    step(1'b0, 1'b1, 4'h0, 8'd12, '0, 1'b0, '0, '0, '0);
    step(1'b1, 1'b1, 4'hF, 8'd12, 32'h5555_5555, 1'b0, '0, '0, '0);
    checks++;
    if (vb0 !== 1'b0 || qb0 !== 32'h0 || qa0 !== 32'h0) begin
      errors++; $display("FAIL rst_flush: got vb=%b qb=%h qa=%h required 0 0 0", vb0, qb0, qa0);
    end
    idle();
    checks++;
    if (vb0 !== 1'b0) begin
      errors++; $display("FAIL rst_no_valid: got vb=%b required 0", vb0);
    end
`ifdef SYNC_RAM_COLLISION_DETECT_EN
    checks++;
    if (col_a !== 1'b0 || caddr_a !== 8'd0) begin
      errors++; $display("FAIL collision_clear: got %b/%0d required 0/0", col_a, caddr_a);
    end
`endif
    step(1'b0, 1'b1, 4'h0, 8'd12, '0, 1'b0, '0, '0, '0);
    idle();
    checks++;
    if (qb0 !== 32'hCAFE_F00D || vb0 !== 1'b1) begin
      errors++; $display("FAIL rst_mem_kept: got %h v=%b required cafef00d v=1", qb0, vb0);
    end
  endtask

  task automatic test_out_of_range();
    step(1'b0, 1'b1, 4'hF, 8'd50, 32'h1234_5678, 1'b0, '0, '0, '0);
    step(1'b0, 1'b1, 4'hF, 8'd250, 32'hFFFF_FFFF, 1'b0, '0, '0, '0);
    step(1'b0, 1'b1, 4'h0, 8'd250, '0, 1'b1, 4'h0, 8'd50, '0);
    checks++;
    if (qa0 !== 32'h0 || va0 !== 1'b1) begin
      errors++; $display("FAIL oor_read: got %h v=%b required 0 v=1", qa0, va0);
    end
    checks++;
    if (qa1 !== 32'h1234_5678) begin
      errors++; $display("FAIL oor_alias: got %h required 12345678", qa1);
    end
    idle();
    checks++;
    if (qb0 !== 32'h0 || vb0 !== 1'b1 || qb1 !== 32'h1234_5678) begin
      errors++; $display("FAIL oor_b: got %h v=%b %h required 0 1 12345678", qb0, vb0, qb1);
    end
  endtask

  task automatic test_random();
    logic          r, e0, e1;
    logic [NB-1:0] w0, w1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] got_q [4];
    logic          got_v [4];
    logic [DW-1:0] want_q [4];
    logic          want_v [4];
    for (int n = 0; n < 400; n++) begin
      r  = ($urandom_range(0, 31) == 0);
      e0 = ($urandom_range(0, 3) != 0);
      e1 = ($urandom_range(0, 3) != 0);
      w0 = ($urandom_range(0, 1) == 0) ? '0 : NB'($urandom_range(0, 15));
      w1 = ($urandom_range(0, 1) == 0) ? '0 : NB'($urandom_range(0, 15));
      a0 = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 255));
      a1 = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 255));
      step(r, e0, w0, a0, $urandom, e1, w1, a1, $urandom);
      got_q[0] = qa0; got_q[1] = qa1; got_q[2] = qb0; got_q[3] = qb1;
      got_v[0] = va0; got_v[1] = va1; got_v[2] = vb0; got_v[3] = vb1;
      want_q[0] = exp_a_q[0]; want_q[1] = exp_a_q[1];
      want_q[2] = exp_b_q[0]; want_q[3] = exp_b_q[1];
      want_v[0] = exp_a_v[0]; want_v[1] = exp_a_v[1];
      want_v[2] = exp_b_v[0]; want_v[3] = exp_b_v[1];
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got_q[k] !== want_q[k] || got_v[k] !== want_v[k]) begin
          errors++;
          $display("FAIL random_out%0d cycle %0d: got %h v=%b required %h v=%b", k, n,
                   got_q[k], got_v[k], want_q[k], want_v[k]);
        end
      end
`ifdef SYNC_RAM_COLLISION_DETECT_EN
      checks++;
      if (col_a !== exp_col || caddr_a !== exp_caddr || col_b !== exp_col ||
          caddr_b !== exp_caddr) begin
        errors++;
        $display("FAIL random_collision cycle %0d: got %b/%0d required %b/%0d", n, col_a,
                 caddr_a, exp_col, exp_caddr);
      end
`endif
    end
  endtask

  initial begin
    rst = 1'b1;
    en0 = 1'b0; we0 = '0; addr0 = '0; d0 = '0;
    en1 = 1'b0; we1 = '0; addr1 = '0; d1 = '0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    for (int p = 0; p < 2; p++) begin
      exp_a_q[p] = '0; exp_a_v[p] = 1'b0;
      exp_b_q[p] = '0; exp_b_v[p] = 1'b0;
      pend_v[p]  = 1'b0; pend_d[p] = '0;
    end
    exp_col   = 1'b0;
    exp_caddr = '0;

    test_reset();
    test_write_readback();
    test_byte_lanes();
    test_dual_write();
    test_rdw();
    test_rst_pipeline();
    test_out_of_range();
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_ram_dp_be.md
Name: sync_ram_dp_be

Overview:
Parametrised dual-port synchronous RAM and the next generation of the team's dual-port block RAM.
- Adds per-port access enable, byte-lane write enables and a selectable read-during-write mode.
- Adds an optional output pipeline register with a read-valid strobe and defined cross-port collision rules.
- Serves as the storage core for the FIFO and cache blocks. Both ports share one clock.

Parameters:
- DWIDTH, 32, data width in bits; must be a multiple of BYTE.
- BYTE, 8, lane width in bits; NB = DWIDTH/BYTE write-enable bits per port.
- AWIDTH, 8, address width.
- DEPTH, 256, number of words; DEPTH <= 2^AWIDTH.
- RDW_MODE, 0, same-port read-during-write: 0 = read-first (old word), 1 = write-first (merged new word).
- OUT_REG, 0, 1 adds an output register stage (read latency 2 instead of 1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en0  in  1  port 0 access enable.
- we0  in  NB  port 0 byte write enables; ignored when en0=0.
- addr0  in  AWIDTH  port 0 word address.
- d0  in  DWIDTH  port 0 write data.
- q0  out  DWIDTH  port 0 read data.
- q0_valid  out  1  q0 holds data from a completed read this cycle.
- en1, we1, addr1, d1, q1, q1_valid: same as port 0, for port 1.
- collision  out  1  sticky collision flag (only with SYNC_RAM_COLLISION_DETECT_EN).
- coll_addr  out  AWIDTH  address of the first collision (only with SYNC_RAM_COLLISION_DETECT_EN).

Behaviour:
- Memory contents start at 0 at time zero and are never cleared by rst.
- While rst=1, all writes are suppressed. rst forces q0/q1, every internal read and output register, and q*_valid to 0.
- Port p access occurs when en_p=1 and rst=0.
  - Bytes b with we_p[b]=1 are written at the edge.
  - A read of mem[addr_p] is captured at the same edge, whether or not the access writes.
- en_p=0: no write; the read register holds its value; q_valid_p=0 on the following response cycle.
- Latency, OUT_REG=0: q_p and q_valid_p=1 appear the cycle after the access. The data holds until the next access; valid is a 1-cycle strobe per access.
- Latency, OUT_REG=1: one more cycle of latency. The output register loads only when the read stage is valid; q_valid is delayed accordingly.
- Back-to-back accesses are supported: one access per port per cycle.
- Same-port read-during-write:
  - RDW_MODE=0 returns the pre-write word.
  - RDW_MODE=1 returns the merged word: written lanes from d_p, the rest old.
- Cross-port, same address, one port writing: the reading port always gets the pre-write word, independent of RDW_MODE.
- Cross-port, both ports writing the same address:
  - A lane enabled on both ports takes port 0 data.
  - A lane enabled on one port only takes that port's data.
- addr_p >= DEPTH: the write is dropped; the read returns 0 with valid still asserted.
- rst asserted mid-pipeline (OUT_REG=1): in-flight reads are discarded; no valid is emitted for them.

Optional Feature:
SYNC_RAM_COLLISION_DETECT_EN
- Defined:
  - A collision is en0 & en1 & (addr0==addr1) & (|we0 | |we1) with rst=0.
  - The first collision sets collision=1 and latches coll_addr the next cycle.
  - Both stay set and unchanged until rst; rst clears them to 0.
- Undefined: the collision and coll_addr ports and all associated logic are absent. Data behaviour is identical in both builds.

Decomposition:
- Package sync_ram_pkg holds:
  - RDW_READ_FIRST=0 and RDW_WRITE_FIRST=1 constants.
  - A byte-merge function (old word, new word, lane enables) -> word, shared by the write path and write-first read.
- Sub-module sync_ram_rd_pipe, instantiated once per port: read-data register, optional output register, valid pipeline and reset clearing.
- The memory array and write arbitration stay in the top module.

Test Plan:
- Write/readback: port0 writes addr 5 = 0xDEADBEEF with we0=4'hF; port1 reads addr 5 the next cycle -> q1=0xDEADBEEF with q1_valid=1 one cycle later (two cycles with OUT_REG=1).
- Byte lanes: addr 3 holds 0x11223344; port0 writes d0=0xAABBCCDD with we0=4'b0101 -> readback 0x11BB33DD.
- RDW modes: addr 7 holds 0x1, port0 writes 0x2 and reads in the same cycle -> q0=0x1 (RDW_MODE=0), q0=0x2 (RDW_MODE=1). Port1 reading addr 7 that cycle -> 0x1 in both modes.
- Dual write conflict: same cycle, port0 writes 0x000000AA with we0=4'b0001, port1 writes 0x0000BBCC with we1=4'b0011 to addr 9 -> readback 0x0000BBAA. With the macro defined: collision=1, coll_addr=9.
- Reset: rst pulsed during an OUT_REG=1 read of a nonzero word -> q=0, q_valid never rises for that read. Memory contents are unchanged when read afterwards.
- Out of range: DEPTH=200, write addr 250 with 0xFFFFFFFF, then read addr 250 -> q=0 with valid=1. addr 250-200=50 is unchanged.
